// File: rtl/mprj_uart_pkg.sv
// Shared types and constants for the user-project UART transmitter.
// Holds the FSM state encoding, the data width and a FIFO level-width helper.
package mprj_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int TIMER_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Occupancy has to represent 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mprj_uart_tx_fifo.sv
// Single-clock byte FIFO whose head entry is held in a register,
// so the consumer can load it on the same edge that pops it.
module mprj_uart_tx_fifo
  import mprj_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          push_data,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          head,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr_inc;
  logic [LW-1:0]        count;
  logic                 do_push;
  logic                 do_pop;

  assign full       = (count == LW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign level      = count;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // The incoming byte becomes the head when it lands in an empty (or emptying) FIFO.
      if (do_push && (empty || (do_pop && count == LW'(1))))
        head <= push_data;
      else if (do_pop)
        head <= mem[rd_ptr_inc];
    end
  end

endmodule

// File: rtl/mprj_uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as 8N1/8N2 frames, LSB first, idle high.
// FSM, bit timer and shift register live here; buffering is in mprj_uart_tx_fifo.
module mprj_uart_tx
  import mprj_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                               clock,
  input  logic                               resetb,
  input  logic                               enable,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

  localparam logic [TIMER_W-1:0] BIT_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]         LAST_STOP  = 3'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic [TIMER_W-1:0]   timer;
  logic                 tx_reg;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 bit_done;
  logic                 frame_end;
  logic                 pop;

  mprj_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign bit_done  = (timer == '0);
  assign frame_end = (state == STOP) && bit_done && (bit_idx == LAST_STOP);
  // enable only gates the start of a frame; an ongoing frame always runs to completion.
  assign pop       = enable && !empty && ((state == IDLE) || frame_end);

  assign tx_ready = !full;
  assign tx       = tx_reg;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      timer   <= '0;
      tx_reg  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            timer   <= BIT_RELOAD;
            tx_reg  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            timer  <= BIT_RELOAD;
            tx_reg <= shift[0];
            state  <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= BIT_RELOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              tx_reg  <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_reg  <= shift[1];
              shift   <= shift >> 1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer <= BIT_RELOAD;
            if (bit_idx != LAST_STOP) begin
              bit_idx <= bit_idx + 1'b1;
            end else if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              tx_reg  <= 1'b0;
              state   <= START;
            end else begin
              bit_idx <= '0;
              state   <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_uart_tx.sv
// Self-checking bench for mprj_uart_tx: table-driven frames, hand-timed corner cases,
// and randomized bursts checked by a line receiver against the queue of accepted bytes.
module tb_mprj_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx, busy;
  logic [LW-1:0] fifo_level;

  logic          enable2 = 1'b0;
  logic [7:0]    tx_data2 = 8'h00;
  logic          tx_valid2 = 1'b0;
  logic          tx_ready2, tx2, busy2;
  logic [LW-1:0] fifo_level2;

  always #5 clock = ~clock;

  mprj_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clock(clock), .resetb(resetb), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  mprj_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clock(clock), .resetb(resetb), .enable(enable2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit k is the line level during bit period k (start first)
  } vec_t;

  vec_t vecs [7];
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_model(input int id, input logic [7:0] d);
    if (id == 0) exp_q0.push_back(d);
    else exp_q1.push_back(d);
  endtask

  // Line receiver: on every falling edge, the next accepted byte must appear as a complete
  // frame of start, 8 data bits LSB first and the stop bits, each exactly CPB cycles long.
  task automatic monitor(input int id);
    int k;
    int flen;
    int idx;
    logic [7:0] b;
    logic bad;
    logic line;
    logic e;
    flen = (9 + ((id == 0) ? 1 : 2)) * CPB;
    k = -1;
    b = 8'h00;
    bad = 1'b0;
    forever begin
      @(negedge clock);
      line = (id == 0) ? tx : tx2;
      if (!resetb) begin
        k = -1;
        continue;
      end
      if (k < 0 && line === 1'b0) begin
        k = 0;
        bad = 1'b0;
        if (qsize(id) == 0) begin
          b = 8'h00;
          bad = 1'b1;
        end else if (id == 0) begin
          b = exp_q0.pop_front();
        end else begin
          b = exp_q1.pop_front();
        end
      end
      if (k >= 0) begin
        idx = k / CPB;
        if (idx == 0) e = 1'b0;
        else if (idx <= 8) e = b[idx-1];
        else e = 1'b1;
        if (line !== e) bad = 1'b1;
        k++;
        if (k == flen) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL frame%0d: line waveform differs from frame of byte %02h at %0t", id, b, $time);
          end
          k = -1;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_idle(input int id, input int budget);
    int n;
    n = 0;
    while ((((id == 0) ? busy : busy2) !== 1'b0 || qsize(id) != 0) && n <= budget) begin
      @(negedge clock);
      n++;
    end
    check((id == 0) ? "idle_wait0" : "idle_wait1", 32'(n <= budget), 32'd1);
  endtask

  // Push one byte into an idle transmitter and follow its frame bit by bit.
  task automatic send_vec(input vec_t v);
    logic bad;
    @(negedge clock);
    tx_data = v.data;
    tx_valid = 1'b1;
    push_model(0, v.data);
    @(negedge clock);
    tx_valid = 1'b0;
    check("vec_level_after_push", 32'(fifo_level), 32'd1);
    check("vec_tx_idle_at_push", 32'(tx), 32'd1);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        if (b == 0 && c == 0) check("vec_level_after_pop", 32'(fifo_level), 32'd0);
        if (tx !== v.frame[b]) bad = 1'b1;
      end
      check($sformatf("vec_%02h_bit%0d", v.data, b), 32'(bad), 32'd0);
    end
    check("vec_busy_in_stop", 32'(busy), 32'd1);
    @(negedge clock);
    check("vec_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fb [10];
    logic [7:0] d;
    logic bad;
    int n;
    int gap;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h55, 10'b1_0101_0101_0};
    vecs[2] = '{8'h0F, 10'b1_0000_1111_0};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[4] = '{8'h3C, 10'b1_0011_1100_0};
    vecs[5] = '{8'h00, 10'b1_0000_0000_0};
    vecs[6] = '{8'h81, 10'b1_1000_0001_0};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    resetb = 1'b1;
    enable = 1'b1;

    // Single-frame vectors
    for (int i = 0; i < 6; i++) send_vec(vecs[i]);

    // Back-to-back frames with level tracking
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i > 0) check("b2b_level_fill", 32'(fifo_level), 32'(i));
      tx_data = (i == 0) ? 8'h55 : (i == 1) ? 8'h0F : 8'hFF;
      tx_valid = 1'b1;
      push_model(0, tx_data);
    end
    @(negedge clock);
    tx_valid = 1'b0;
    check("b2b_level_full3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    @(negedge clock);
    check("b2b_start1_tx", 32'(tx), 32'd0);
    check("b2b_start1_level", 32'(fifo_level), 32'd2);
    repeat (39) @(negedge clock);
    check("b2b_stop1_tx", 32'(tx), 32'd1);
    @(negedge clock);
    check("b2b_start2_tx", 32'(tx), 32'd0);
    check("b2b_start2_level", 32'(fifo_level), 32'd1);
    repeat (40) @(negedge clock);
    check("b2b_start3_tx", 32'(tx), 32'd0);
    check("b2b_start3_level", 32'(fifo_level), 32'd0);
    wait_idle(0, 200);

    // Full FIFO with valid held
    enable = 1'b0;
    for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data = fb[0];
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      push_model(0, fb[i-1]);
      tx_data = fb[i];
    end
    check("full_ready", 32'(tx_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd8);
    repeat (3) @(negedge clock);
    check("full_level_held", 32'(fifo_level), 32'd8);
    enable = 1'b1;
    @(negedge clock);
    check("full_pop_level", 32'(fifo_level), 32'd7);
    check("full_pop_ready", 32'(tx_ready), 32'd1);
    @(negedge clock);
    push_model(0, fb[8]);
    check("full_refill_level", 32'(fifo_level), 32'd8);
    tx_data = fb[9];
    repeat (38) @(negedge clock);
    check("full_wait_level", 32'(fifo_level), 32'd8);
    @(negedge clock);
    check("full_pop2_level", 32'(fifo_level), 32'd7);
    @(negedge clock);
    push_model(0, fb[9]);
    check("full_refill2_level", 32'(fifo_level), 32'd8);
    tx_valid = 1'b0;
    wait_idle(0, 600);

    // Enable dropped during DATA bit 3
    @(negedge clock);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    push_model(0, 8'h3C);
    @(negedge clock);
    tx_data = 8'h5A;
    push_model(0, 8'h5A);
    @(negedge clock);
    tx_valid = 1'b0;
    check("endrop_level", 32'(fifo_level), 32'd1);
    repeat (17) @(negedge clock);
    enable = 1'b0;
    repeat (23) @(negedge clock);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("endrop_tx_held_high", 32'(bad), 32'd0);
    check("endrop_level_kept", 32'(fifo_level), 32'd1);
    check("endrop_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    @(negedge clock);
    check("endrop_resume_tx", 32'(tx), 32'd0);
    check("endrop_resume_level", 32'(fifo_level), 32'd0);
    wait_idle(0, 200);

    // Reset during DATA bit 5
    @(negedge clock);
    tx_data = 8'h96;
    tx_valid = 1'b1;
    push_model(0, 8'h96);
    @(negedge clock);
    tx_data = 8'h44;
    push_model(0, 8'h44);
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (25) @(negedge clock);
    check("rstmid_pre_tx", 32'(tx), 32'd0);
    resetb = 1'b0;
    #1;
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_level", 32'(fifo_level), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(tx_ready), 32'd1);
    exp_q0.delete();
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    send_vec(vecs[6]);

    // Randomized bursts that never overfill the FIFO
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        gap = $urandom_range(3, 0);
        @(negedge clock);
        check("rand_ready", 32'(tx_ready), 32'd1);
        tx_data = d;
        tx_valid = 1'b1;
        push_model(0, d);
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
      wait_idle(0, 400);
    end

    // Two stop bits: 8-cycle stop interval, 44-cycle frame period
    enable2 = 1'b1;
    @(negedge clock);
    tx_data2 = 8'h00;
    tx_valid2 = 1'b1;
    push_model(1, 8'h00);
    @(negedge clock);
    tx_data2 = 8'h01;
    push_model(1, 8'h01);
    @(negedge clock);
    tx_valid2 = 1'b0;
    check("s2_first_fall", 32'(tx2), 32'd0);
    repeat (35) @(negedge clock);
    check("s2_last_data", 32'(tx2), 32'd0);
    @(negedge clock);
    check("s2_stop_begin", 32'(tx2), 32'd1);
    repeat (7) @(negedge clock);
    check("s2_stop_end", 32'(tx2), 32'd1);
    @(negedge clock);
    check("s2_second_fall", 32'(tx2), 32'd0);
    wait_idle(1, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mprj_uart_tx.md
Name: mprj_uart_tx

Overview:
- User-project UART transmitter: the sending end of the serial link the testbench UART monitor receives on mprj_io[6].
- Firmware or user logic pushes bytes through a valid/ready port into a small FIFO.
- The block serialises them as 8N1 (or 8N2) frames, LSB first, idle-high.
- Lets user-project RTL report results over UART without the management core's UART.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per bit (40 MHz / 9600 baud); legal range 2..65535.
- FIFO_DEPTH, 8, byte entries; power of two, 2..64.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  asynchronous active-low reset.
- enable  input  1  transmitter enable; gates frame start only.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept; equals not full.
- tx  output  1  serial output, idle high.
- busy  output  1  high while a frame is in flight or FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync-free deassert) forces:
  - tx=1, busy=0, fifo_level=0, tx_ready=1.
  - FSM to IDLE; FIFO pointers cleared.
  - Applies mid-frame too: frame aborted, tx high immediately, FIFO contents discarded.
- Push: tx_valid && tx_ready at edge N writes tx_data; fifo_level increments after N. tx_valid while full is ignored; the upstream must hold it.
- Pop and push in the same edge: level unchanged; data ordering preserved.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if enable && level>0 at an edge, pop the head into shift register, bit_idx=0, timer=CLKS_PER_BIT-1, go START. tx is registered, so tx=0 from that edge.
- Latency: byte pushed into an empty FIFO at edge N with enable=1 and FSM in IDLE → tx falls at edge N+1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go DATA with tx=shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit 7, go STOP with tx=1.
  - bit_idx is 3 bits and must not wrap before the transition.
- STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
  - if enable && level>0, pop and go directly to START (no idle gap; back-to-back frames);
  - else go IDLE.
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles from tx fall to earliest next fall.
- enable deasserted mid-frame: current frame completes unchanged; no new frame starts. Pushes are still accepted.
- busy = (state!=IDLE) || (level!=0).
- Bit timer: 16-bit down-counter, reloaded at every bit boundary; no cumulative drift.

Decomposition:
- Package mprj_uart_pkg holds:
  - state enum (IDLE/START/DATA/STOP, 2 bits);
  - DATA_BITS=8;
  - localparam helpers for level width.
- Sub-module mprj_uart_tx_fifo is a synchronous single-clock FIFO:
  - push/pop/full/empty/level ports;
  - registered read data at head;
  - same async active-low reset.
- FSM, timer and shifter stay in mprj_uart_tx.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0xA5 at edge N → tx=0 for 4 cycles from N+1, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1. busy drops after the stop bit. Total 40 cycles.
- Back-to-back: push 0x55, 0x0F, 0xFF in consecutive cycles → three contiguous 40-cycle frames, no idle gap. fifo_level reads 1,2,3 then decrements at each frame start. Decoded bytes match in order.
- Full FIFO: FIFO_DEPTH=8, enable=0, push 10 bytes with valid held → tx_ready=0 after 8 accepts, level=8. Raise enable → exactly the 8 first bytes are sent, then the remaining 2 are accepted as space frees.
- Enable drop mid-frame: deassert enable during DATA bit 3 of 0x3C → frame completes correctly. The queued next byte is not sent until enable returns; tx stays 1 meanwhile.
- Reset mid-frame: assert resetb=0 during DATA bit 5 → tx=1 same timestep, level=0, busy=0. After release, a new push of 0x81 transmits a clean frame.
- STOP_BITS=2: push 0x00 then 0x01 → stop interval 8 cycles, frame period 44 cycles; a receiver bench decodes 0x00, 0x01.
